// File: rtl/assert_ctrl_multi_pkg.sv
// Shared types for the assertion-control unit: command opcodes,
// per-channel and global state encodings, and a small op classifier.
package assert_ctrl_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    ON   = 3'd1,
    OFF  = 3'd2,
    KILL = 3'd3,
    CLR  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    CH_OFF    = 2'd0,
    CH_ON     = 2'd1,
    CH_LOCKED = 2'd2
  } ch_state_e;

  typedef enum logic {
    GS_WARMUP = 1'b0,
    GS_RUN    = 1'b1
  } glob_state_e;

  // KILL and CLR both zero the counter and are the only ops that can release a lock
  function automatic logic is_clear_op(input op_e op);
    logic res;
    case (op)
      KILL:    res = 1'b1;
      CLR:     res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/assert_ctrl_multi_if.sv
// Command port of the assertion-control unit (valid/ready handshake).
interface assert_ctrl_multi_if #(
  parameter int unsigned N_CH = 4
) ();
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                   cmd_valid;
  logic                   cmd_ready;
  assert_ctrl_pkg::op_e   cmd_op;
  logic                   cmd_bcast;
  logic [CH_W-1:0]        cmd_ch;

  modport master (
    output cmd_valid, cmd_op, cmd_bcast, cmd_ch,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_bcast, cmd_ch,
    output cmd_ready
  );
endinterface

// File: rtl/assert_ctrl_multi_ch.sv
// One assertion channel: OFF/ON/LOCKED state, saturating failure counter
// and auto-lock. A fail pulse is judged against the state held at the start
// of the cycle and counted before any same-cycle command takes effect.
module assert_ch_ctrl
  import assert_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_FAILS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_start,
  input  logic             cmd_hit,
  input  op_e              cmd_op,
  input  logic             fail_in,
  output logic             chk_en,
  output logic             fail_out,
  output logic             locked,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             lock_set,
  output logic             locked_nxt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  ch_state_e        state_r;
  ch_state_e        state_nxt_s;
  ch_state_e        st_f_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [CNT_W-1:0] cnt_f_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             counted_s;
  logic             thresh_s;
  logic             chk_en_r;
  logic             locked_r;
  logic             fail_out_r;

  // Fail accounting against the pre-cycle state: saturating increment and threshold detect
  always_comb begin
    counted_s = (state_r == CH_ON) && fail_in;
    cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_W'(1'b1));
    thresh_s  = counted_s && (MAX_FAILS != 32'd0) && (32'(cnt_inc_s) == MAX_FAILS);
    st_f_s    = thresh_s ? CH_LOCKED : state_r;
    cnt_f_s   = counted_s ? cnt_inc_s : cnt_r;
  end

  // Command applied on top of the fail outcome; a fresh lock beats ON/OFF,
  // while KILL/CLR act on the channel as it stood at the start of the cycle
  always_comb begin
    state_nxt_s = st_f_s;
    cnt_nxt_s   = cnt_f_s;
    if (run_start) begin
      state_nxt_s = CH_ON;
    end else if (cmd_hit) begin
      case (cmd_op)
        ON:      state_nxt_s = (st_f_s == CH_OFF) ? CH_ON : st_f_s;
        OFF:     state_nxt_s = (st_f_s == CH_ON) ? CH_OFF : st_f_s;
        KILL: begin
          state_nxt_s = CH_OFF;
          cnt_nxt_s   = CNT_ZERO;
        end
        CLR: begin
          state_nxt_s = (state_r == CH_ON) ? CH_ON : CH_OFF;
          cnt_nxt_s   = CNT_ZERO;
        end
        default: state_nxt_s = st_f_s;
      endcase
    end else begin
      state_nxt_s = st_f_s;
    end
  end

  // Lock-entry and next-lock indications feed the shared sticky error flag
  always_comb begin
    locked_nxt = (state_nxt_s == CH_LOCKED);
    lock_set   = (state_nxt_s == CH_LOCKED) && (state_r != CH_LOCKED);
  end

  // Channel state, counter and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= CH_OFF;
      cnt_r      <= CNT_ZERO;
      chk_en_r   <= 1'b0;
      locked_r   <= 1'b0;
      fail_out_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      chk_en_r   <= (state_nxt_s == CH_ON);
      locked_r   <= (state_nxt_s == CH_LOCKED);
      fail_out_r <= fail_in & chk_en_r;
    end
  end

  assign chk_en   = chk_en_r;
  assign locked   = locked_r;
  assign fail_out = fail_out_r;
  assign fail_cnt = cnt_r;

endmodule

// File: rtl/assert_ctrl_multi.sv
// N-channel assertion-control unit: post-reset warm-up, command decode,
// per-channel controllers and a sticky lock error flag.
module assert_ctrl_multi
  import assert_ctrl_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_FAILS = 3,
  parameter int unsigned WARMUP    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  assert_ctrl_multi_if.slave    cmd,
  input  logic [N_CH-1:0]       fail_in,
  output logic [N_CH-1:0]       chk_en,
  output logic [N_CH-1:0]       fail_out,
  output logic [N_CH-1:0]       locked,
  output logic [N_CH*CNT_W-1:0] fail_cnt,
  output logic                  err
);

  localparam int unsigned   WU_W    = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WU_W-1:0] WU_INIT = WU_W'(WARMUP);

  glob_state_e     glob_r;
  logic [WU_W-1:0] warm_cnt_r;
  logic            cmd_ready_r;
  logic            err_r;
  logic            run_start_s;
  logic            cmd_fire_s;
  logic            clr_fire_s;
  logic            ch_ok_s;
  logic [N_CH-1:0] hit_s;
  logic [N_CH-1:0] lock_set_s;
  logic [N_CH-1:0] locked_nxt_s;

  // Global warm-up/run sequencer; commands are only accepted once running
  always_ff @(posedge clk) begin
    if (rst) begin
      glob_r      <= GS_WARMUP;
      warm_cnt_r  <= WU_INIT;
      cmd_ready_r <= 1'b0;
    end else begin
      case (glob_r)
        GS_WARMUP: begin
          if (warm_cnt_r == {WU_W{1'b0}}) begin
            glob_r      <= GS_RUN;
            cmd_ready_r <= 1'b1;
          end else begin
            warm_cnt_r  <= warm_cnt_r - WU_W'(1'b1);
            cmd_ready_r <= 1'b0;
          end
        end
        GS_RUN: begin
          glob_r      <= GS_RUN;
          cmd_ready_r <= 1'b1;
        end
        default: begin
          glob_r      <= GS_WARMUP;
          warm_cnt_r  <= WU_INIT;
          cmd_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Command decode: accepted handshake, channel range check and per-channel hit mask
  always_comb begin
    run_start_s = (glob_r == GS_WARMUP) && (warm_cnt_r == {WU_W{1'b0}});
    cmd_fire_s  = cmd.cmd_valid && cmd_ready_r;
    clr_fire_s  = cmd_fire_s && is_clear_op(cmd.cmd_op);
    ch_ok_s     = (32'(cmd.cmd_ch) < N_CH);
    hit_s       = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      hit_s[i] = cmd_fire_s && (cmd.cmd_bcast || (ch_ok_s && (32'(cmd.cmd_ch) == 32'(i))));
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      assert_ch_ctrl #(
        .CNT_W     (CNT_W),
        .MAX_FAILS (MAX_FAILS)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .run_start  (run_start_s),
        .cmd_hit    (hit_s[g]),
        .cmd_op     (cmd.cmd_op),
        .fail_in    (fail_in[g]),
        .chk_en     (chk_en[g]),
        .fail_out   (fail_out[g]),
        .locked     (locked[g]),
        .fail_cnt   (fail_cnt[g*CNT_W +: CNT_W]),
        .lock_set   (lock_set_s[g]),
        .locked_nxt (locked_nxt_s[g])
      );
    end
  endgenerate

  // Sticky error: set on any new lock, released by a clear-type command that leaves nothing locked
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (|lock_set_s) begin
      err_r <= 1'b1;
    end else if (clr_fire_s && !(|locked_nxt_s)) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign cmd.cmd_ready = cmd_ready_r;
  assign err           = err_r;

endmodule

// File: tb/tb_assert_ctrl_multi.sv
// Self-checking bench for assert_ctrl_multi: two instances (default
// parameters, and a narrow non-locking variant) driven by directed and
// random stimulus and compared every cycle against a rule-level model.
module tb_assert_ctrl_multi;
  import assert_ctrl_pkg::*;

  logic clk;
  logic rst;

  logic       v   [2];
  logic [2:0] op  [2];
  logic       bc  [2];
  logic [1:0] ch  [2];
  logic [3:0] fin [2];

  logic [3:0] en  [2];
  logic [3:0] lk  [2];
  logic [3:0] fo  [2];
  logic       erro[2];
  logic       rdy [2];
  logic [31:0] cnt_a;
  logic [7:0]  cnt_b;

  int n_chk;
  int n_err;
  bit started;

  // model parameters per instance
  int cw [2] = '{8, 2};
  int mf [2] = '{3, 0};
  int wu [2] = '{16, 3};

  // model state: 0 off, 1 on, 2 locked
  int m_age [2];
  bit m_run [2];
  int m_st  [2][4];
  int m_cnt [2][4];
  bit m_fo  [2][4];
  bit m_err [2];

  assert_ctrl_multi_if #(.N_CH(4)) if_a ();
  assert_ctrl_multi_if #(.N_CH(4)) if_b ();

  assign if_a.cmd_valid = v[0];
  assign if_a.cmd_op    = op_e'(op[0]);
  assign if_a.cmd_bcast = bc[0];
  assign if_a.cmd_ch    = ch[0];
  assign if_b.cmd_valid = v[1];
  assign if_b.cmd_op    = op_e'(op[1]);
  assign if_b.cmd_bcast = bc[1];
  assign if_b.cmd_ch    = ch[1];
  assign rdy[0] = if_a.cmd_ready;
  assign rdy[1] = if_b.cmd_ready;

  assert_ctrl_multi #(.N_CH(4), .CNT_W(8), .MAX_FAILS(3), .WARMUP(16)) u_a (
    .clk(clk), .rst(rst), .cmd(if_a), .fail_in(fin[0]), .chk_en(en[0]),
    .fail_out(fo[0]), .locked(lk[0]), .fail_cnt(cnt_a), .err(erro[0])
  );

  assert_ctrl_multi #(.N_CH(4), .CNT_W(2), .MAX_FAILS(0), .WARMUP(3)) u_b (
    .clk(clk), .rst(rst), .cmd(if_b), .fail_in(fin[1]), .chk_en(en[1]),
    .fail_out(fo[1]), .locked(lk[1]), .fail_cnt(cnt_b), .err(erro[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference rules for one instance over one clock edge
  task automatic model_step(input int k);
    bit acc, new_lock, any_locked;
    int pre, s, c;
    if (rst) begin
      m_age[k] = 0; m_run[k] = 1'b0; m_err[k] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_st[k][i] = 0; m_cnt[k][i] = 0; m_fo[k][i] = 1'b0;
      end
      return;
    end
    acc = v[k] && m_run[k];
    new_lock = 1'b0;
    any_locked = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pre = m_st[k][i];
      s = pre;
      c = m_cnt[k][i];
      m_fo[k][i] = fin[k][i] && (pre == 1);
      if (pre == 1 && fin[k][i]) begin
        if (c < (1 << cw[k]) - 1) c = c + 1;
        if (mf[k] != 0 && c == mf[k]) s = 2;
      end
      if (acc && (bc[k] || int'(ch[k]) == i)) begin
        case (int'(op[k]))
          1: if (s == 0) s = 1;
          2: if (s == 1) s = 0;
          3: begin s = 0; c = 0; end
          4: begin c = 0; s = (pre == 1) ? 1 : 0; end
          default: ;
        endcase
      end
      if (s == 2 && pre != 2) new_lock = 1'b1;
      if (s == 2) any_locked = 1'b1;
      m_st[k][i] = s;
      m_cnt[k][i] = c;
    end
    if (new_lock) m_err[k] = 1'b1;
    else if (acc && (op[k] == 3'd3 || op[k] == 3'd4) && !any_locked) m_err[k] = 1'b0;
    if (!m_run[k]) begin
      if (m_age[k] == wu[k]) begin
        m_run[k] = 1'b1;
        for (int i = 0; i < 4; i++) m_st[k][i] = 1;
      end else begin
        m_age[k]++;
      end
    end
  endtask

  // Advance the model on the same edge the DUTs sample
  always @(posedge clk) begin
    if (rst) started <= 1'b1;
    model_step(0);
    model_step(1);
  end

  // Compare every observable output on the inactive edge
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        logic [3:0] e_en, e_lk, e_fo;
        string nm;
        nm = (k == 0) ? "A" : "B";
        for (int i = 0; i < 4; i++) begin
          e_en[i] = (m_st[k][i] == 1);
          e_lk[i] = (m_st[k][i] == 2);
          e_fo[i] = m_fo[k][i];
        end
        chk({nm, ".cmd_ready"}, 32'(rdy[k]), 32'(m_run[k]));
        chk({nm, ".chk_en"},    32'(en[k]),  32'(e_en));
        chk({nm, ".locked"},    32'(lk[k]),  32'(e_lk));
        chk({nm, ".fail_out"},  32'(fo[k]),  32'(e_fo));
        chk({nm, ".err"},       32'(erro[k]), 32'(m_err[k]));
        for (int i = 0; i < 4; i++) begin
          if (k == 0) chk($sformatf("A.fail_cnt%0d", i), 32'(cnt_a[i*8 +: 8]), 32'(m_cnt[0][i]));
          else        chk($sformatf("B.fail_cnt%0d", i), 32'(cnt_b[i*2 +: 2]), 32'(m_cnt[1][i]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle_cmds();
    for (int k = 0; k < 2; k++) begin
      v[k] = 1'b0; op[k] = 3'd0; bc[k] = 1'b0; ch[k] = 2'd0;
    end
  endtask

  task automatic cmd_a(input logic [2:0] o, input logic b, input logic [1:0] c);
    v[0] = 1'b1; op[0] = o; bc[0] = b; ch[0] = c;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    started = 1'b0;
    rst = 1'b1;
    idle_cmds();
    fin[0] = 4'hF;
    fin[1] = 4'h0;
    repeat (2) step();
    rst = 1'b0;

    // warm-up with every checker failing; instance B takes 5 fails on ch0 once running
    for (int i = 0; i < 17; i++) begin
      fin[1] = (i >= 5 && i < 10) ? 4'h1 : 4'h0;
      step();
    end
    fin[0] = 4'h0;
    fin[1] = 4'h0;
    step();

    // three counted failures lock channel 1
    for (int i = 0; i < 3; i++) begin
      fin[0] = 4'h2; step();
      fin[0] = 4'h0; step();
    end

    // ON is ignored while locked; CLR releases; ON re-enables
    cmd_a(3'd1, 1'b0, 2'd1); step();
    cmd_a(3'd4, 1'b0, 2'd1); step();
    cmd_a(3'd1, 1'b0, 2'd1); step();
    idle_cmds(); step();

    // fail and OFF on the same channel in the same cycle
    fin[0] = 4'h4;
    cmd_a(3'd2, 1'b0, 2'd2); step();
    fin[0] = 4'h0;
    idle_cmds(); step();

    // broadcast KILL then broadcast ON
    cmd_a(3'd3, 1'b1, 2'd0); step();
    cmd_a(3'd1, 1'b1, 2'd3); step();
    idle_cmds(); step();

    // reset in the middle of activity on both instances
    fin[0] = 4'h5; fin[1] = 4'h1;
    cmd_a(3'd4, 1'b0, 2'd0);
    rst = 1'b1; step();
    rst = 1'b0; idle_cmds();
    fin[0] = 4'h0; fin[1] = 4'h0;
    repeat (20) step();

    // randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 2; k++) begin
        v[k]  = ($urandom_range(0, 99) < 30);
        op[k] = 3'($urandom_range(0, 4));
        bc[k] = ($urandom_range(0, 9) == 0);
        ch[k] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 4; i++) fin[k][i] = ($urandom_range(0, 3) == 0);
      end
      rst = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 1'b0;
    idle_cmds();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
